uart_tx_queue: RTL

//   Byte FIFO directly upstream of the UART transmitter. Host writes bytes at any rate;
//   the queue drains them one at a time into uart_tx via its tx_start/tx_data/tx_busy/tx_done

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_sync_fifo.sv | 63 ++++++
 rtl/uart_tx_queue.sv | 95 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: transmitter byte width and the 2-bit launch FSM encoding
// used by uart_tx_queue.
package uart_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte FIFO with a separate level counter; rd_data shows the head with no latency.
// A write while full is dropped, and a read while empty is ignored.
module uart_sync_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level
);

  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Both qualifiers look at the pre-edge level, so a full-cycle write is dropped
  // even if a pop frees a slot on the same edge.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign full    = (level == LVL_FULL);
  assign empty   = (level == '0);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Host-side byte queue feeding uart_tx via tx_start/tx_data/tx_busy/tx_done; bytes are dropped when full.
// UART_TXQ_OVF_EN adds a sticky ovf flag (set wins over ovf_clr) and its ovf_clr input.
module uart_tx_queue #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = uart_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              tx_start,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_busy,
  input  logic              tx_done
`ifdef UART_TXQ_OVF_EN
  ,
  output logic              ovf,
  input  logic              ovf_clr
`endif
);

  import uart_pkg::*;

  logic [1:0]        state;
  logic              pop;
  logic [DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  assign pop = (state == ST_IDLE) && !empty && !tx_busy;

  // tx_data is only reloaded on a pop, so it holds from tx_start through tx_done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            tx_data  <= head;
            tx_start <= 1'b1;
            state    <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (tx_done) begin
            state <= ST_IDLE;
          end else if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TXQ_OVF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule
